// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode, register ID, status and writeback FSM definitions
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RSP      = 4'h4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;
    typedef enum logic {RUN, STOP} wb_state_t;
endpackage

// File: rtl/wb_dst_sel.sv
// wb_dst_sel: combinational writeback destination selection
// Ports: icode, rA, rB, cnd in; dstE (valE target), dstM (valM target) out, RNONE when unused.
module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);
    always_comb begin
        dstE = (icode == I_RRMOVQ) ? (cnd ? rB : RNONE) :
               (icode == I_IRMOVQ || icode == I_OPQ) ? rB :
               (icode == I_CALL || icode == I_RET || icode == I_PUSHQ || icode == I_POPQ) ? RSP :
               RNONE;
        dstM = (icode == I_MRMOVQ || icode == I_POPQ) ? rA : RNONE;
    end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 writeback stage with 15-entry register file, stop FSM and retire counter
// Ports: clk, rst (async high); wb_en, icode, rA, rB, cnd, valE, valM, stat in;
//        rax..r14 register contents, halted, stat_out, retired out.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic [2:0]       stat,
    output logic [WIDTH-1:0] rax,
    output logic [WIDTH-1:0] rcx,
    output logic [WIDTH-1:0] rdx,
    output logic [WIDTH-1:0] rbx,
    output logic [WIDTH-1:0] rsp,
    output logic [WIDTH-1:0] rbp,
    output logic [WIDTH-1:0] rsi,
    output logic [WIDTH-1:0] rdi,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic             halted,
    output logic [2:0]       stat_out,
    output logic [CNT_W-1:0] retired
);
    logic [WIDTH-1:0] rf [15];
    logic [3:0]       dstE, dstM;
    wb_state_t        state;

    wb_dst_sel u_sel (.icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .dstE(dstE), .dstM(dstM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) rf[i] <= '0;
            retired  <= '0;
            halted   <= 1'b0;
            stat_out <= S_AOK;
            state    <= RUN;
        end else if (wb_en && state == RUN) begin
            if (stat == S_AOK) begin
                retired <= retired + CNT_W'(1);
                // popq %rsp: E is suppressed so the loaded value lands
                if (dstE != RNONE && dstE != dstM) rf[dstE] <= valE;
                if (dstM != RNONE) rf[dstM] <= valM;
            end else begin
                state    <= STOP;
                halted   <= 1'b1;
                stat_out <= stat;
            end
        end
    end

    assign rax = rf[0];
    assign rcx = rf[1];
    assign rdx = rf[2];
    assign rbx = rf[3];
    assign rsp = rf[4];
    assign rbp = rf[5];
    assign rsi = rf[6];
    assign rdi = rf[7];
    assign r8  = rf[8];
    assign r9  = rf[9];
    assign r10 = rf[10];
    assign r11 = rf[11];
    assign r12 = rf[12];
    assign r13 = rf[13];
    assign r14 = rf[14];
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed self-checking bench with an instruction-level reference model
module tb_writeback_regfile;
    logic        clk = 0, rst = 1, wb_en = 0, cnd = 0;
    logic [3:0]  icode = 0, rA = 4'hF, rB = 4'hF;
    logic [63:0] valE = 0, valM = 0;
    logic [2:0]  stat = 1;
    logic [63:0] r [15];
    logic        halted;
    logic [2:0]  stat_out;
    logic [31:0] retired;

    logic [63:0] m_rf [15];
    logic [31:0] m_ret;
    logic        m_halt;
    logic [2:0]  m_stat;
    int n_cmp = 0, n_bad = 0;

    writeback_regfile dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .stat(stat),
        .rax(r[0]), .rcx(r[1]), .rdx(r[2]), .rbx(r[3]), .rsp(r[4]), .rbp(r[5]), .rsi(r[6]),
        .rdi(r[7]), .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]), .r12(r[12]), .r13(r[13]),
        .r14(r[14]), .halted(halted), .stat_out(stat_out), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 15; i++) m_rf[i] = 0;
        m_ret = 0; m_halt = 0; m_stat = 1;
    endfunction

    function automatic void m_put(logic [3:0] id, logic [63:0] v);
        if (id != 4'hF) m_rf[id] = v;
    endfunction

    // Instruction semantics: E result first, M result second, so M overrides on a clash
    function automatic void m_commit(logic w, logic [3:0] ic, logic [3:0] a, logic [3:0] b,
                                     logic c, logic [63:0] e, logic [63:0] m, logic [2:0] s);
        if (!w || m_halt) return;
        if (s != 1) begin m_halt = 1; m_stat = s; return; end
        m_ret++;
        case (ic)
            4'h2: if (c) m_put(b, e);
            4'h3, 4'h6: m_put(b, e);
            4'h5: m_put(a, m);
            4'h8, 4'h9, 4'hA: m_put(4, e);
            4'hB: begin m_put(4, e); m_put(a, m); end
            default: ;
        endcase
    endfunction

    always @(negedge clk) if (!rst) begin
        for (int i = 0; i < 15; i++) chk($sformatf("reg%0d", i), r[i], m_rf[i]);
        chk("retired", 64'(retired), 64'(m_ret));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("stat_out", 64'(stat_out), 64'(m_stat));
    end

    task automatic step(logic w, logic [3:0] ic, logic [3:0] a, logic [3:0] b, logic c,
                        logic [63:0] e, logic [63:0] m, logic [2:0] s);
        wb_en = w; icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; stat = s;
        @(posedge clk);
        m_commit(w, ic, a, b, c, e, m, s);
        @(negedge clk);
        wb_en = 0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_rax", r[0], 0);
        chk("rst_retired", 64'(retired), 0);
        chk("rst_halted", 64'(halted), 0);
        chk("rst_stat", 64'(stat_out), 1);
        rst = 0;
        step(1, 4'h3, 4'hF, 4'h2, 0, 5, 0, 1);
        chk("irmov_rdx", r[2], 5);
        chk("irmov_ret", 64'(retired), 1);
        step(1, 4'h2, 4'h1, 4'h8, 0, 7, 0, 1);
        chk("cmov0_r8", r[8], 0);
        step(1, 4'h2, 4'h1, 4'h8, 1, 7, 0, 1);
        chk("cmov1_r8", r[8], 7);
        step(1, 4'h3, 4'hF, 4'h4, 0, 64'h100, 0, 1);
        step(1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'h1234, 1);
        chk("poprsp", r[4], 64'h1234);
        step(1, 4'h3, 4'hF, 4'h4, 0, 64'h100, 0, 1);
        step(1, 4'hA, 4'h3, 4'hF, 0, 64'hF8, 0, 1);
        chk("push_rsp", r[4], 64'hF8);
        step(1, 4'hB, 4'h3, 4'hF, 0, 64'h100, 9, 1);
        chk("pop_rbx", r[3], 9);
        chk("pop_rsp", r[4], 64'h100);
        step(0, 4'h3, 4'hF, 4'h1, 0, 99, 0, 3);
        chk("wb0_rcx", r[1], 0);
        chk("wb0_halted", 64'(halted), 0);
        step(1, 4'hC, 4'h1, 4'h1, 1, 55, 66, 1);
        chk("icodeC_rcx", r[1], 0);
        step(1, 4'h5, 4'h6, 4'hF, 0, 0, 64'h55, 1);
        chk("mrmov_rsi", r[6], 64'h55);
        chk("ret10", 64'(retired), 10);
        step(1, 4'h3, 4'hF, 4'h0, 0, 64'h77, 0, 1);
        step(1, 4'h6, 4'hF, 4'h0, 0, 64'hAA, 0, 3);
        chk("adr_halted", 64'(halted), 1);
        chk("adr_stat", 64'(stat_out), 3);
        chk("adr_rax", r[0], 64'h77);
        chk("adr_ret", 64'(retired), 11);
        step(1, 4'h3, 4'hF, 4'h0, 0, 1, 0, 1);
        step(1, 4'h3, 4'hF, 4'h0, 0, 2, 0, 2);
        chk("stop_rax", r[0], 64'h77);
        chk("stop_ret", 64'(retired), 11);
        chk("stop_stat", 64'(stat_out), 3);
        #2 rst = 1;
        #1;
        chk("arst_rax", r[0], 0);
        chk("arst_rsp", r[4], 0);
        chk("arst_ret", 64'(retired), 0);
        chk("arst_halted", 64'(halted), 0);
        chk("arst_stat", 64'(stat_out), 1);
        m_reset();
        #1 rst = 0;
        @(negedge clk);
        step(1, 4'h3, 4'hF, 4'h5, 0, 64'h42, 0, 1);
        chk("post_rbp", r[5], 64'h42);
        chk("post_ret", 64'(retired), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
